dm_arbiter: RTL
===============

// Module: dm_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer in front of data_mem. It serialises
//  load/store requests from master 0 (core LSU) and master 1 (debug/DMA) onto the
//  single dm_* port. The data_mem read path is combinational and its write commits
//  at posedge, so this block registers each command and returns a registered response.
// PARAMETERS
//  AW  32  address width of masters and dm_addr (data_mem decodes [9:2])
//  DW  32  data width
// PORTS
//  clk            in   1   single clock, all logic posedge
//  rst_n          in   1   synchronous reset, active-low
//  mX_req         in   1   X=0,1: request valid; fields held stable until mX_gnt
//  mX_we          in   1   1 = store, 0 = load
//  mX_func        in   3   WORD 000, HALF 001, BYTE 010, HALFU 101, BYTEU 110
//  mX_addr        in   AW  byte address
//  mX_wdata       in   DW  store data, right-aligned
//  mX_gnt         out  1   one-cycle pulse: command accepted and driven to memory
//  mX_rvalid      out  1   one-cycle pulse, cycle after mX_gnt: completion (load and store)
//  mX_rdata       out  DW  load data, valid with mX_rvalid; 0 for stores
//  mX_err         out  1   valid with mX_rvalid; constant 0 unless macro enabled
//  dm_func        out  3   to data_mem
//  dm_we          out  1   to data_mem
//  dm_addr        out  AW  to data_mem
//  dm_din         out  DW  to data_mem
//  dm_dout        in   DW  from data_mem, combinational
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, rr_last=1, all gnt/rvalid/err=0,
//    rdata=0, cmd regs (func/we/addr/din/owner)=0.
//  - dm_we = (state==ACCESS) & cmd_we & rst_n & ~cmd_err, so no write commits at
//    a reset edge, even mid-ACCESS.
//  - FSM: IDLE, ACCESS, RESP.
//    IDLE:   any req -> latch winner's fields into cmd regs, owner=winner, ->ACCESS.
//    ACCESS: dm_* driven from cmd regs; gnt[owner]=1; rdata_q<=cmd_we?0:dm_dout;
//            rr_last<=owner; ->RESP. No arbitration in this state.
//    RESP:   rvalid[owner]=1, rdata/err from regs; arbitrates as IDLE does
//            (any req -> ACCESS next, else ->IDLE).
//  - Latency: req seen at cycle t -> gnt at t+1 -> rvalid at t+2. Peak throughput
//    is 1 access per 2 cycles.
//  - Arbitration: single req wins. If both req, winner = ~rr_last (m0 first after
//    reset). Losing req must stay high; it wins next arbitration (no starvation).
//  - A req still high during RESP is a new request. Masters drop req in the cycle
//    after gnt if they have nothing further.
//  - dm_addr/dm_func/dm_din hold cmd values outside ACCESS; only dm_we qualifies.
//  - func is passed through unchanged. Lane steering and sign/zero extension are
//    done in data_mem.
// CONFIGURATION
//  DM_ARB_ALIGN_CHK_EN defined: cmd_err is latched with the command. It is set for:
//    WORD with addr[1:0]!=0; HALF/HALFU with addr[0]!=0; func in {011,100,111};
//    HALFU/BYTEU with we=1.
//    With cmd_err set: dm_we is suppressed, mX_err=1 with rvalid, rdata=0, and the
//    handshake timing is unchanged.
//  Undefined: cmd_err tied 0, mX_err constant 0, every request forwarded as-is.
// STRUCTURE
//  - dm_pkg: func codes (DM_WORD..DM_BYTEU) and FSM state encoding (2-bit).
//    data_mem is to migrate to the same codes.
//  - Sub-module dm_rr_arb: 2-way round-robin picker.
//    Inputs: req[1:0], last. Outputs: any, winner. Purely combinational.
//    The FSM, cmd registers and response registers stay in dm_arbiter.
// TESTING
//  1. m0 SW 0xDEADBEEF @0x10, then LW @0x10.
//     -> gnt at t+1, rvalid at t+2; rdata=0xDEADBEEF; dm_we high exactly 1 cycle.
//  2. m0 and m1 req in the same cycle after reset, held.
//     -> grants m0, m1, m0, m1 in alternation; each gnt 2 cycles apart.
//  3. SB 0x80 @0x13, then LB @0x13 and LBU @0x13.
//     -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
//  4. rst_n low in the ACCESS cycle of SW 0x12345678 @0x20.
//     -> no write (a later LW @0x20 returns the prior value); all outputs 0 next cycle.
//  5. With DM_ARB_ALIGN_CHK_EN: SW @0x22.
//     -> dm_we never high, m0_err=1 with rvalid, rdata=0.
//     Without the macro: the write occurs and err=0.
//  6. m1 req held while m0 issues 4 back-to-back loads.
//     -> m1 granted no later than the 2nd arbitration.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data_mem arbiter: func codes, FSM states
// and the command legality check used when DM_ARB_ALIGN_CHK_EN is defined.
package dm_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_BYTE  = 3'b010;
  localparam logic [2:0] DM_HALFU = 3'b101;
  localparam logic [2:0] DM_BYTEU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

  function automatic logic dm_cmd_err(
    input logic [2:0] f,
    input logic       we,
    input logic [1:0] a
  );
    logic e;
    case (f)
      DM_WORD:  e = |a;
      DM_HALF:  e = a[0];
      DM_HALFU: e = a[0] | we;
      DM_BYTE:  e = 1'b0;
      DM_BYTEU: e = we;
      default:  e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bundle for the two masters of dm_arbiter.
// master = requester side, slave = arbiter side.
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [2:0]    m0_func;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m0_err;

  logic          m1_req;
  logic          m1_we;
  logic [2:0]    m1_func;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          m1_err;

  modport master (
    output m0_req, m0_we, m0_func, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_func, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err
  );

  modport slave (
    input  m0_req, m0_we, m0_func, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_func, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err
  );

endinterface

// File: rtl/dm_arbiter_rr.sv
// Two-way round-robin picker: a lone request wins,
// on contention the master that did not win last time goes.
module dm_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  assign any    = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer in front of data_mem.
// DM_ARB_ALIGN_CHK_EN: reject misaligned/illegal commands with err.
import dm_pkg::*;

module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arbiter_if.slave   bus,
  output logic [2:0]    dm_func,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout
);

  dm_state_e     state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [2:0]    func_q, func_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          any, winner;
  logic          w_we;
  logic [2:0]    w_func;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  dm_rr_arb u_rr (
    .req    ({bus.m1_req, bus.m0_req}),
    .last   (rr_last_q),
    .any    (any),
    .winner (winner)
  );

  always_comb begin
    w_we    = winner ? bus.m1_we    : bus.m0_we;
    w_func  = winner ? bus.m1_func  : bus.m0_func;
    w_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    w_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    err_d     = err_q;
    func_d    = func_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (any) begin
          state_d = ST_ACCESS;
          owner_d = winner;
          we_d    = w_we;
          func_d  = w_func;
          addr_d  = w_addr;
          din_d   = w_wdata;
`ifdef DM_ARB_ALIGN_CHK_EN
          err_d   = dm_cmd_err(w_func, w_we, w_addr[1:0]);
`else
          err_d   = 1'b0;
`endif
        end
      end
      ST_ACCESS: begin
        state_d   = ST_RESP;
        rr_last_d = owner_q;
        rdata_d   = (we_q | err_q) ? '0 : dm_dout;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      func_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      err_q     <= err_d;
      func_q    <= func_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
    end
  end

  // rst_n gates the strobe so a reset edge mid-ACCESS never commits
  assign dm_we   = (state_q == ST_ACCESS) & we_q & rst_n & ~err_q;
  assign dm_func = func_q;
  assign dm_addr = addr_q;
  assign dm_din  = din_q;

  assign bus.m0_gnt    = (state_q == ST_ACCESS) & ~owner_q;
  assign bus.m1_gnt    = (state_q == ST_ACCESS) &  owner_q;
  assign bus.m0_rvalid = (state_q == ST_RESP)   & ~owner_q;
  assign bus.m1_rvalid = (state_q == ST_RESP)   &  owner_q;
  assign bus.m0_err    = bus.m0_rvalid & err_q;
  assign bus.m1_err    = bus.m1_rvalid & err_q;
  assign bus.m0_rdata  = rdata_q;
  assign bus.m1_rdata  = rdata_q;

endmodule
